hdmi_audio_i2s_tx: RTL and testbench
====================================

# hdmi_audio_i2s_tx

Audio output stage of the HDMI path. Accepts 16-bit PCM samples from the audio source (test feeder or, later, the SPU) over a valid/ready handshake and buffers them in a small FIFO. Serializes them as standard I2S (SCLK, LRCLK, SD) into the ADV7511 audio input. Consecutive accepted samples alternate left, right, left, and so on.

## Interface
Parameters:
- SAMPLE_WIDTH, 16: bits per sample; also I2S slot width.
- FIFO_DEPTH, 8: sample FIFO entries; power of two, at least 2.
- SCLK_DIV, 4: clk cycles per SCLK half-period; at least 1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; one clock, asynchronous, active-low.
- en  in  1  serializer enable; FIFO accepts data regardless.
- in_data  in  SAMPLE_WIDTH  PCM sample, two's complement.
- in_valid  in  1  in_data valid.
- in_rdy  out  1  FIFO not full.
- i2s_sclk  out  1  bit clock to ADV7511.
- i2s_lrclk  out  1  word select; 0 = left, 1 = right.
- i2s_sd  out  1  serial data, MSB first.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- underrun  out  1  sticky; set when a slot starts with the FIFO empty.

## Operation
- Push: a sample is accepted on any clk edge with in_valid & in_rdy. in_rdy = (level != FIFO_DEPTH), computed from the registered level only; there is no bypass.
- Divider: counter div_cnt runs 0..SCLK_DIV-1. At terminal count, i2s_sclk toggles and div_cnt returns to 0. A falling event is a terminal count while i2s_sclk = 1.
- Serializer, on each falling event:
  - i2s_sd <= shreg[MSB]; shreg <= shreg << 1; bit_cnt increments (wraps 15 -> 0).
  - If bit_cnt == SAMPLE_WIDTH-1: i2s_lrclk toggles, and shreg loads the popped FIFO head.
  - If the FIFO is empty, shreg loads 0 and underrun is set.
  - Result: LRCLK changes one SCLK before the new word's MSB, which is the I2S one-bit delay.
- Channel order: the slot after LRCLK falls is left; the slot after it rises is right. One pop per slot.
- Disable: while en = 0, div_cnt, bit_cnt, shreg, sclk, lrclk and sd hold their reset values. FIFO contents and level are kept.
- Simultaneous push and pop: level is unchanged. If full, the push is refused because in_rdy was already 0. If empty, the pop underruns and the pushed word is stored for the next slot.
- FIFO pointers wrap modulo FIFO_DEPTH.
- underrun is cleared only by reset.

## Timing
- Reset values:
  - i2s_sclk = 0, i2s_lrclk = 1, i2s_sd = 0.
  - bit_cnt = SAMPLE_WIDTH-1, shreg = 0, div_cnt = 0.
  - fifo_level = 0, in_rdy = 1, underrun = 0.
- All outputs are registered, except in_rdy, which is a compare on the registered level.
- fifo_level reflects a push or pop one clk after it.
- After en rises, with SCLK_DIV = D:
  - First SCLK rising edge after D clks.
  - First falling event at 2D clks: LRCLK goes 0 and the first left word is popped.
  - That word's MSB appears on SD at the next falling event (4D clks).
- SCLK period = 2·SCLK_DIV clk. Frame = 2·SAMPLE_WIDTH SCLK periods.
- Reset mid-frame: everything returns to reset values asynchronously and FIFO contents are discarded.
- Clearing en mid-frame drops the word in shreg. The FIFO is not rewound.

## Structure
- Shared package hdmi_pkg holds:
  - typedef audio_sample_t = logic [15:0].
  - constant I2S_SLOT_BITS = 16.
  - enum i2s_chan_t {LEFT, RIGHT}.
- Sub-module hdmi_audio_fifo: synchronous FIFO with push/pop/full/empty/level and the same clk/rst_n. The top level holds the divider, bit counter, shifter and LRCLK logic.
- Expected size: 150–250 lines total.

## Test plan
- Reset: drive rst_n low mid-operation. Expect outputs at reset values immediately, fifo_level = 0 and in_rdy = 1.
- Fill: en = 0, push 8 samples with in_valid held high. Expect in_rdy = 0 after the 8th accept, fifo_level = 8, and a 9th sample (16'h1234) not accepted.
- Serialize: en = 1, SCLK_DIV = 4, push 16'hA5C3 then 16'h0F01. Sample SD on SCLK rising edges. Expect left slot = A5C3 and right slot = 0F01, each MSB one SCLK after the LRCLK edge.
- Underrun: en = 1 with an empty FIFO. Expect zeros on SD and underrun = 1 after the first slot. Push 16'h8001; expect it in the next slot and underrun to stay 1.
- Simultaneous push/pop: level = 1 and a push on the pop cycle. Expect level to stay 1 and order to be preserved.
- Enable drop: clear en mid-slot. Expect SCLK/LRCLK/SD to return to 0/1/0 and fifo_level unchanged. Re-enable; expect the next word to go out as a left-channel word.

Source files
------------

// File: rtl/hdmi_pkg.sv
// Shared HDMI audio types: sample word, I2S slot size and channel encoding.
// The channel enum value doubles as the LRCLK level (0 = left, 1 = right).
package hdmi_pkg;

  localparam int I2S_SLOT_BITS = 16;

  typedef logic [15:0] audio_sample_t;

  typedef enum logic {
    LEFT  = 1'b0,
    RIGHT = 1'b1
  } i2s_chan_t;

  function automatic i2s_chan_t other_chan(input i2s_chan_t c);
    return (c == LEFT) ? RIGHT : LEFT;
  endfunction

endpackage

// File: rtl/hdmi_audio_fifo.sv
// Synchronous sample FIFO with registered occupancy; pushes when full and pops
// when empty are ignored, so the caller may gate them or not.
module hdmi_audio_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             do_push, do_pop;

  assign full_o  = (level_q == FULL_LVL);
  assign empty_o = (level_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign rdata_o = mem_q[rd_ptr_q];
  assign level_o = level_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/hdmi_audio_i2s_tx.sv
// HDMI audio output stage: buffers PCM samples and serializes them as I2S
// (SCLK/LRCLK/SD, MSB first, one-bit delay) for the ADV7511 audio input.
module hdmi_audio_i2s_tx
  import hdmi_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 16,
  parameter int FIFO_DEPTH   = 8,
  parameter int SCLK_DIV     = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic [SAMPLE_WIDTH-1:0]       in_data,
  input  logic                          in_valid,
  output logic                          in_rdy,
  output logic                          i2s_sclk,
  output logic                          i2s_lrclk,
  output logic                          i2s_sd,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          underrun
);

  localparam int DIV_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam int BIT_W = (SAMPLE_WIDTH > 1) ? $clog2(SAMPLE_WIDTH) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(SAMPLE_WIDTH - 1);

  logic [DIV_W-1:0]        div_cnt_q, div_cnt_d;
  logic [BIT_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic [SAMPLE_WIDTH-1:0] shreg_q, shreg_d;
  logic                    sclk_q, sclk_d;
  i2s_chan_t               lrclk_q, lrclk_d;
  logic                    sd_q, sd_d;
  logic                    underrun_q, underrun_d;

  logic                    div_tc;
  logic                    fall_evt;
  logic                    pop;
  logic [SAMPLE_WIDTH-1:0] fifo_rdata;
  logic                    fifo_full, fifo_empty;

  // Input handshake: a sample transfers on any clk edge where in_valid and
  // in_rdy are both high; in_rdy depends only on the registered level, never
  // on in_valid or on a same-cycle pop.
  hdmi_audio_fifo #(
    .WIDTH (SAMPLE_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (in_valid),
    .wdata_i (in_data),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  assign in_rdy   = ~fifo_full;
  assign div_tc   = (div_cnt_q == DIV_LAST);
  assign fall_evt = en & div_tc & sclk_q;

  always_comb begin
    div_cnt_d  = div_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    sclk_d     = sclk_q;
    lrclk_d    = lrclk_q;
    sd_d       = sd_q;
    underrun_d = underrun_q;
    pop        = 1'b0;

    if (!en) begin
      div_cnt_d = '0;
      bit_cnt_d = BIT_LAST;
      shreg_d   = '0;
      sclk_d    = 1'b0;
      lrclk_d   = RIGHT;
      sd_d      = 1'b0;
    end else begin
      if (div_tc) begin
        div_cnt_d = '0;
        sclk_d    = ~sclk_q;
      end else begin
        div_cnt_d = div_cnt_q + DIV_W'(1);
      end

      // LRCLK flips on the same falling edge that shifts out the previous
      // word's LSB, so the new word's MSB lands one SCLK later.
      if (fall_evt) begin
        sd_d      = shreg_q[SAMPLE_WIDTH-1];
        shreg_d   = shreg_q << 1;
        bit_cnt_d = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + BIT_W'(1);
        if (bit_cnt_q == BIT_LAST) begin
          lrclk_d = other_chan(lrclk_q);
          if (fifo_empty) begin
            shreg_d    = '0;
            underrun_d = 1'b1;
          end else begin
            shreg_d = fifo_rdata;
            pop     = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q  <= '0;
      bit_cnt_q  <= BIT_LAST;
      shreg_q    <= '0;
      sclk_q     <= 1'b0;
      lrclk_q    <= RIGHT;
      sd_q       <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      div_cnt_q  <= div_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      sclk_q     <= sclk_d;
      lrclk_q    <= lrclk_d;
      sd_q       <= sd_d;
      underrun_q <= underrun_d;
    end
  end

  assign i2s_sclk  = sclk_q;
  assign i2s_lrclk = logic'(lrclk_q);
  assign i2s_sd    = sd_q;
  assign underrun  = underrun_q;

endmodule

// File: tb/tb_hdmi_audio_i2s_tx.sv
// Bench for hdmi_audio_i2s_tx: timing-arithmetic reference model plus an I2S
// receiver that rebuilds each slot from SD sampled on SCLK rising edges.
module tb_hdmi_audio_i2s_tx;
  import hdmi_pkg::*;

  localparam int SW    = 16;
  localparam int DEPTH = 8;
  localparam int D     = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          in_valid = 1'b0;
  audio_sample_t in_data = '0;
  logic          in_rdy, i2s_sclk, i2s_lrclk, i2s_sd, underrun;
  logic [LW-1:0] fifo_level;

  always #5 clk = ~clk;

  hdmi_audio_i2s_tx #(
    .SAMPLE_WIDTH (SW),
    .FIFO_DEPTH   (DEPTH),
    .SCLK_DIV     (D)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_rdy     (in_rdy),
    .i2s_sclk   (i2s_sclk),
    .i2s_lrclk  (i2s_lrclk),
    .i2s_sd     (i2s_sd),
    .fifo_level (fifo_level),
    .underrun   (underrun)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  audio_sample_t m_fifo[$];
  logic [16:0]   exp_q[$];   // {channel, word} per slot, in emission order
  logic          m_underrun;
  int            en_cycles;  // enabled clk edges since enable
  int            slots;      // slots started since enable
  logic          prev_en;

  // Receiver state
  logic          prev_sclk, prev_lr, dec_active, dec_chan;
  int            dec_cnt;
  logic [15:0]   dec_acc;
  logic [16:0]   dec_log[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Falling events occur every 2D enabled edges; every 16th one (starting
  // with the first) begins a slot and pops the FIFO.
  function automatic bit is_pop(input int n);
    return (n % (2 * D) == 0) && (((n / (2 * D)) % SW) == 1);
  endfunction

  task automatic dec_reset();
    prev_sclk  = 1'b0;
    prev_lr    = 1'b1;
    dec_active = 1'b0;
    dec_cnt    = 0;
    dec_acc    = '0;
    dec_chan   = 1'b0;
  endtask

  task automatic model_clear();
    m_fifo.delete();
    exp_q.delete();
    m_underrun = 1'b0;
    en_cycles  = 0;
    slots      = 0;
    prev_en    = 1'b0;
    dec_reset();
  endtask

  task automatic observe();
    logic exp_sclk, exp_lr;
    logic [16:0] want;
    exp_sclk = 1'((en_cycles / D) % 2);
    exp_lr   = (slots == 0) ? 1'b1 : ((slots % 2 == 1) ? 1'b0 : 1'b1);
    check("sclk", 32'(i2s_sclk), 32'(exp_sclk));
    check("lrclk", 32'(i2s_lrclk), 32'(exp_lr));
    check("level", 32'(fifo_level), 32'(m_fifo.size()));
    check("in_rdy", 32'(in_rdy), 32'(m_fifo.size() != DEPTH));
    check("underrun", 32'(underrun), 32'(m_underrun));
    if (!en) check("sd_idle", 32'(i2s_sd), 32'd0);

    if (!prev_sclk && i2s_sclk) begin
      if (dec_active) begin
        dec_acc = {dec_acc[14:0], i2s_sd};
        dec_cnt++;
        if (dec_cnt == SW) begin
          dec_active = 1'b0;
          dec_log.push_back({dec_chan, dec_acc});
          if (exp_q.size() == 0) begin
            check("slot_extra", 32'(exp_q.size()), 32'd1);
          end else begin
            want = exp_q.pop_front();
            check("slot", 32'({dec_chan, dec_acc}), 32'(want));
          end
        end
      end
      if (i2s_lrclk != prev_lr) begin
        dec_active = 1'b1;
        dec_cnt    = 0;
        dec_chan   = i2s_lrclk;
      end
      prev_lr = i2s_lrclk;
    end
    prev_sclk = i2s_sclk;
  endtask

  // Drive one cycle's inputs, advance the model across the coming edge,
  // then check the DUT on the following falling clk edge.
  task automatic step(input logic e, input logic v, input audio_sample_t d);
    bit   rdy_before;
    logic ch;
    en       = e;
    in_valid = v;
    in_data  = d;
    rdy_before = (m_fifo.size() != DEPTH);
    if (e) begin
      en_cycles++;
      if (is_pop(en_cycles)) begin
        ch = (slots % 2 == 1);
        if (m_fifo.size() == 0) begin
          exp_q.push_back({ch, 16'h0000});
          m_underrun = 1'b1;
        end else begin
          exp_q.push_back({ch, m_fifo.pop_front()});
        end
        slots++;
      end
    end else begin
      if (prev_en) begin
        exp_q.delete();
        dec_reset();
      end
      en_cycles = 0;
      slots     = 0;
    end
    prev_en = e;
    if (v && rdy_before) m_fifo.push_back(d);
    @(posedge clk);
    @(negedge clk);
    observe();
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_sclk", 32'(i2s_sclk), 32'd0);
    check("rst_lrclk", 32'(i2s_lrclk), 32'd1);
    check("rst_sd", 32'(i2s_sd), 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_rdy", 32'(in_rdy), 32'd1);
    check("rst_underrun", 32'(underrun), 32'd0);
    model_clear();
    en       = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int lvl;
    int off_cnt;
    int rate;
    model_clear();
    repeat (2) @(negedge clk);
    do_reset();
    repeat (3) step(1'b0, 1'b0, '0);

    // Fill with the serializer off, then offer one more word
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, audio_sample_t'($urandom));
    check("fill_rdy", 32'(in_rdy), 32'd0);
    check("fill_level", 32'(fifo_level), 32'(DEPTH));
    step(1'b0, 1'b1, 16'h1234);
    check("full_refuse_level", 32'(fifo_level), 32'(DEPTH));
    check("full_rdy", 32'(in_rdy), 32'd0);
    step(1'b0, 1'b0, '0);

    // Drain the eight words and run into underrun, then reset mid-frame
    for (int i = 0; i < 8 * 128 + 200; i++) step(1'b1, 1'b0, '0);
    do_reset();

    // Directed serialize / underrun sequence
    dec_log.delete();
    step(1'b0, 1'b1, 16'hA5C3);
    step(1'b0, 1'b1, 16'h0F01);
    step(1'b0, 1'b0, '0);
    for (int i = 0; i < 560; i++)
      step(1'b1, (i == 300), (i == 300) ? 16'h8001 : 16'h0000);
    check("ser_left", 32'(dec_log[0]), 32'({1'b0, 16'hA5C3}));
    check("ser_right", 32'(dec_log[1]), 32'({1'b1, 16'h0F01}));
    check("ser_underrun_zero", 32'(dec_log[2]), 32'({1'b0, 16'h0000}));
    check("ser_after_underrun", 32'(dec_log[3]), 32'({1'b1, 16'h8001}));
    check("underrun_sticky", 32'(underrun), 32'd1);
    do_reset();

    // Push exactly on the pop edges with one word queued
    step(1'b0, 1'b1, audio_sample_t'($urandom));
    step(1'b0, 1'b0, '0);
    for (int i = 0; i < 300; i++)
      step(1'b1, is_pop(en_cycles + 1), audio_sample_t'($urandom));
    check("simul_level", 32'(fifo_level), 32'd1);

    // Drop enable mid-slot, then re-enable
    for (int i = 0; i < 200; i++) step(1'b1, (i < 3), audio_sample_t'($urandom));
    lvl = m_fifo.size();
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, '0);
    check("drop_sclk", 32'(i2s_sclk), 32'd0);
    check("drop_lrclk", 32'(i2s_lrclk), 32'd1);
    check("drop_sd", 32'(i2s_sd), 32'd0);
    check("drop_level", 32'(fifo_level), 32'(lvl));
    dec_log.delete();
    for (int i = 0; i < 300; i++) step(1'b1, 1'b0, '0);
    check("reenable_left", 32'(dec_log[0][16]), 32'd0);

    // Random traffic with occasional enable drops
    off_cnt = 0;
    for (int i = 0; i < 6000; i++) begin
      rate = (i < 3000) ? 30 : 5;
      if (off_cnt == 0 && $urandom_range(0, 999) == 0) off_cnt = $urandom_range(1, 40);
      step((off_cnt == 0), ($urandom_range(0, 999) < rate), audio_sample_t'($urandom));
      if (off_cnt > 0) off_cnt--;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
